// File: rtl/circuit7_pkg.sv
// Shared types for circuit7_seq: controller state encoding and its width.
package circuit7_pkg;

   localparam int STATE_WIDTH = 2;

   typedef enum logic [STATE_WIDTH-1:0] {
      IDLE   = 2'd0,
      DIV_AB = 2'd1,
      DIV_CD = 2'd2,
      DONE   = 2'd3
   } StateT;

endpackage

// File: rtl/circuit7_seq_div_iter.sv
// Restoring radix-2 divider: one quotient bit per cycle, DATAWIDTH cycles per job.
// The load edge already performs the first step, so valid follows DATAWIDTH edges after load.
module div_iter #(
   parameter int DATAWIDTH = 64
) (
   input  logic                 clock,
   input  logic                 resetN,
   input  logic                 load,
   input  logic [DATAWIDTH-1:0] dividend,
   input  logic [DATAWIDTH-1:0] divisor,
   output logic                 busy,
   output logic                 valid,
   output logic [DATAWIDTH-1:0] quotient,
   output logic [DATAWIDTH-1:0] remainder
);

   localparam int CW = $clog2(DATAWIDTH + 1);

   logic [DATAWIDTH-1:0] remReg;
   logic [DATAWIDTH-1:0] quoReg;
   logic [DATAWIDTH-1:0] divReg;
   logic [CW-1:0]        count;
   logic                 running;

   logic [DATAWIDTH-1:0] srcRem;
   logic [DATAWIDTH-1:0] srcQuo;
   logic [DATAWIDTH-1:0] srcDiv;
   logic [DATAWIDTH:0]   shifted;
   logic [DATAWIDTH+1:0] trial;
   logic                 fits;
   logic [DATAWIDTH-1:0] nextRem;
   logic [DATAWIDTH-1:0] nextQuo;

   // One restoring step; a true remainder never needs the guard bit, so a set guard bit in
   // the difference can only mean the trial subtraction went negative.
   always_comb begin
      srcRem  = load ? '0 : remReg;
      srcQuo  = load ? dividend : quoReg;
      srcDiv  = load ? divisor : divReg;
      shifted = {srcRem, srcQuo[DATAWIDTH-1]};
      trial   = {1'b0, shifted} - {2'b00, srcDiv};
      fits    = ~trial[DATAWIDTH+1] & ~trial[DATAWIDTH];
      nextRem = fits ? trial[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0];
      nextQuo = {srcQuo[DATAWIDTH-2:0], fits};
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         remReg  <= '0;
         quoReg  <= '0;
         divReg  <= '0;
         count   <= '0;
         running <= 1'b0;
      end else if (load) begin
         remReg  <= nextRem;
         quoReg  <= nextQuo;
         divReg  <= divisor;
         count   <= CW'(DATAWIDTH - 1);
         running <= 1'b1;
      end else if (running) begin
         if (count != '0) begin
            remReg <= nextRem;
            quoReg <= nextQuo;
            count  <= count - CW'(1);
         end else begin
            running <= 1'b0;
         end
      end
   end

   assign busy      = running && (count != '0);
   assign valid     = running && (count == '0);
   assign quotient  = quoReg;
   assign remainder = remReg;

endmodule

// File: rtl/circuit7_seq.sv
// circuit7_seq: z = ((a mod b) == zero) ? a/b : c/d on one shared iterative divider.
// Define CIRCUIT7_SEQ_SKIP_EN to skip the c/d division when its result would be discarded.
import circuit7_pkg::*;

module circuit7_seq #(
   parameter int DATAWIDTH = 64
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [DATAWIDTH-1:0] c,
   input  logic [DATAWIDTH-1:0] d,
   input  logic [DATAWIDTH-1:0] zero,
   output logic                 busy,
   output logic                 done,
   output logic [DATAWIDTH-1:0] z,
   output logic                 gEQz
);

   StateT state, nextState;

   logic [DATAWIDTH-1:0] cReg, dReg, zeroReg;
   logic [DATAWIDTH-1:0] eReg, fReg, gReg;
   logic                 divLoad, divBusy, divValid;
   logic [DATAWIDTH-1:0] divDividend, divDivisor, divQuo, divRem;

   div_iter #(.DATAWIDTH(DATAWIDTH)) divUnit (
      .clock    (Clk),
      .resetN   (Rst),
      .load     (divLoad),
      .dividend (divDividend),
      .divisor  (divDivisor),
      .busy     (divBusy),
      .valid    (divValid),
      .quotient (divQuo),
      .remainder(divRem)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= nextState;
   end

   // a/b is loaded straight from the ports on the accepting edge; c/d come from the captured copies.
   always_comb begin
      nextState   = state;
      divLoad     = 1'b0;
      divDividend = a;
      divDivisor  = b;
      case (state)
         IDLE: begin
            if (start) begin
               divLoad   = 1'b1;
               nextState = DIV_AB;
            end
         end
         DIV_AB: begin
            if (divValid) begin
`ifdef CIRCUIT7_SEQ_SKIP_EN
               if (divRem == zeroReg) begin
                  nextState = DONE;
               end else begin
                  divLoad     = 1'b1;
                  divDividend = cReg;
                  divDivisor  = dReg;
                  nextState   = DIV_CD;
               end
`else
               divLoad     = 1'b1;
               divDividend = cReg;
               divDivisor  = dReg;
               nextState   = DIV_CD;
`endif
            end
         end
         DIV_CD: begin
            if (divValid) nextState = DONE;
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Datapath registers; z and gEQz change only on the DONE edge, together with the done pulse.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cReg    <= '0;
         dReg    <= '0;
         zeroReg <= '0;
         eReg    <= '0;
         fReg    <= '0;
         gReg    <= '0;
         z       <= '0;
         gEQz    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            cReg    <= c;
            dReg    <= d;
            zeroReg <= zero;
         end
         if (state == DIV_AB && divValid) begin
            eReg <= divQuo;
            gReg <= divRem;
         end
         if (state == DIV_CD && divValid) begin
            fReg <= divQuo;
         end
         if (state == DONE) begin
            z    <= (gReg == zeroReg) ? eReg : fReg;
            gEQz <= (gReg == zeroReg);
            done <= 1'b1;
         end
      end
   end

   assign busy = (state != IDLE) || divBusy;

endmodule

// File: tb/tb_circuit7_seq.sv
// Directed self-checking bench for circuit7_seq at DATAWIDTH=64; works with or without CIRCUIT7_SEQ_SKIP_EN.
module tb_circuit7_seq;

   localparam int W         = 64;
   localparam int FULL_LAT  = 2 * W + 1;
   localparam int SHORT_LAT = W + 1;
`ifdef CIRCUIT7_SEQ_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   logic         Clk = 1'b0;
   logic         Rst;
   logic         start;
   logic [W-1:0] a, b, c, d, zero;
   logic         busy, done, gEQz;
   logic [W-1:0] z;

   int errors = 0;
   int checks = 0;

   circuit7_seq #(.DATAWIDTH(W)) dut (
      .Clk  (Clk),
      .Rst  (Rst),
      .start(start),
      .a    (a),
      .b    (b),
      .c    (c),
      .d    (d),
      .zero (zero),
      .busy (busy),
      .done (done),
      .z    (z),
      .gEQz (gEQz)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [W-1:0] aV, bV, cV, dV, zV);
      a     = aV;
      b     = bV;
      c     = cV;
      d     = dV;
      zero  = zV;
      start = 1'b1;
   endtask

   // Waits for done, counting edges from the accepting edge (already 'soFar' edges elapsed).
   task automatic waitDone(input string tag, input int soFar, input logic [W-1:0] expZ, input bit expEq);
      int n;
      int expLat;
      n      = soFar;
      expLat = (SKIP_EN && expEq) ? SHORT_LAT : FULL_LAT;
      while (!done && n < 400) begin
         @(posedge Clk);
         #1;
         n++;
      end
      checkOutput({tag, " latency"}, 64'(n), 64'(expLat));
      checkOutput({tag, " z"}, z, expZ);
      checkOutput({tag, " gEQz"}, 64'(gEQz), 64'(expEq));
   endtask

   task automatic runJob(input string tag, input logic [W-1:0] aV, bV, cV, dV, zV,
                         input logic [W-1:0] expZ, input bit expEq);
      applyStimulus(aV, bV, cV, dV, zV);
      @(posedge Clk);
      #1;
      start = 1'b0;
      checkOutput({tag, " busy"}, 64'(busy), 64'd1);
      waitDone(tag, 0, expZ, expEq);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Rst   = 1'b0;
      start = 1'b0;
      a = '0; b = '0; c = '0; d = '0; zero = '0;
      #1;
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset z", z, 64'd0);
      checkOutput("reset gEQz", 64'(gEQz), 64'd0);
      repeat (2) @(posedge Clk);
      #2;
      Rst = 1'b1;

      runJob("rem equals zero", 64'd100, 64'd7, 64'd50, 64'd5, 64'd2, 64'd14, 1'b1);
      runJob("rem differs", 64'd100, 64'd7, 64'd50, 64'd5, 64'd0, 64'd10, 1'b0);
      runJob("b zero", 64'd9, 64'd0, 64'd50, 64'd5, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      runJob("max by three", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd1000, 64'd10, 64'd0,
             64'h5555_5555_5555_5555, 1'b1);
      runJob("d zero", 64'd255, 64'd16, 64'd1000, 64'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      runJob("guard bit", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd7, 64'd2,
             64'h7FFF_FFFF_FFFF_FFFE, 64'd1, 1'b1);

      // A second start while busy, with new operands on the ports, must be ignored.
      applyStimulus(64'd100, 64'd7, 64'd50, 64'd5, 64'd2);
      @(posedge Clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge Clk);
      #4;
      applyStimulus(64'd1000, 64'd10, 64'd3, 64'd1, 64'd0);
      @(posedge Clk);
      #1;
      start = 1'b0;
      waitDone("ignored start", 6, 64'd14, 1'b1);
      checkOutput("done before back-to-back", 64'(done), 64'd1);
      runJob("back-to-back", 64'd1000, 64'd10, 64'd3, 64'd1, 64'd0, 64'd100, 1'b1);

      // Asynchronous reset in the middle of a job.
      applyStimulus(64'd100, 64'd7, 64'd50, 64'd5, 64'd0);
      @(posedge Clk);
      #1;
      start = 1'b0;
      repeat (40) @(posedge Clk);
      #2;
      Rst = 1'b0;
      #1;
      checkOutput("midjob reset busy", 64'(busy), 64'd0);
      checkOutput("midjob reset z", z, 64'd0);
      checkOutput("midjob reset done", 64'(done), 64'd0);
      checkOutput("midjob reset gEQz", 64'(gEQz), 64'd0);
      #3;
      Rst = 1'b1;
      runJob("after reset", 64'd255, 64'd16, 64'd1000, 64'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

      @(posedge Clk);
      #1;
      checkOutput("done single cycle", 64'(done), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/circuit7_seq.md
CIRCUIT7_SEQ -- requirements
Module: circuit7_seq

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 64, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port Clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
REQ-005 SHALL have ports a, b, c, d, zero, input, DATAWIDTH each, unsigned operands; captured on the edge that accepts start.
REQ-006 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-007 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-008 SHALL have port z, output, DATAWIDTH, registered result; holds its value until the next done.
REQ-009 SHALL have port gEQz, output, 1, registered flag: (a mod b) == zero for the last completed job.

Function
REQ-010 SHALL compute e = a/b, g = a mod b and f = c/d, all unsigned; z = gEQz ? e : f.
REQ-011 SHALL time-share one iterative divider for all divisions; the divider SHALL produce quotient and remainder together, so a/b yields both e and g.
REQ-012 SHALL implement the FSM states IDLE, DIV_AB, DIV_CD and DONE.
REQ-013 SHALL make the following FSM transitions:
- IDLE -> DIV_AB: on an edge with start=1.
- DIV_AB: run for DATAWIDTH cycles, then latch e and g, evaluate gEQz, and go to DIV_CD.
- DIV_CD: run for DATAWIDTH cycles, then latch f and go to DONE.
- DONE: load z and gEQz, assert done, and go to IDLE.
REQ-014 SHALL assert done exactly 2*DATAWIDTH+1 edges after the accepting edge (without CIRCUIT7_SEQ_SKIP_EN).
REQ-015 SHALL ignore start while busy; the operands of an in-flight job SHALL NOT change.
REQ-016 SHALL accept start in the cycle immediately after done (back-to-back jobs).
REQ-017 SHALL use this divide-by-zero rule: divisor 0 gives quotient all ones and remainder equal to the dividend; no error flag.
REQ-018 SHALL use DATAWIDTH-bit internal arithmetic plus one guard bit for the partial remainder; no truncation of results.

Reset
REQ-019 SHALL, on Rst=0, force IDLE immediately regardless of clock, including mid-division, and discard any in-flight job.
REQ-020 SHALL give these reset values: busy=0, done=0, z=0, gEQz=0, divider counter=0, and all internal e/f/g registers 0.
REQ-021 SHALL, after Rst deasserts, accept start on the first rising edge.

Configuration
REQ-022 SHALL, when CIRCUIT7_SEQ_SKIP_EN is defined, go from DIV_AB directly to DONE if g == zero, skipping DIV_CD; done latency is then DATAWIDTH+1 edges in that case.
REQ-023 SHALL, when CIRCUIT7_SEQ_SKIP_EN is undefined, always execute DIV_CD, giving a fixed 2*DATAWIDTH+1 latency.
REQ-024 SHALL keep the z and gEQz values identical with and without CIRCUIT7_SEQ_SKIP_EN.

Structure
REQ-025 SHALL place the state enum (IDLE/DIV_AB/DIV_CD/DONE) and the state-width constant in shared package circuit7_pkg.
REQ-026 SHALL instantiate one sub-module, div_iter: restoring radix-2 divider with load/busy/valid, parameterized by DATAWIDTH, returning quotient and remainder.
REQ-027 SHALL NOT instantiate any other divider, mod or comp block; the comparison is inline.

Verification
REQ-028 SHALL cover: DATAWIDTH=64, a=100, b=7, c=50, d=5, zero=2, start pulse -> g=2, gEQz=1, z=14, done at edge 129.
REQ-029 SHALL cover: a=100, b=7, c=50, d=5, zero=0 -> gEQz=0, z=10, done at edge 129 (same edge with SKIP_EN).
REQ-030 SHALL cover: with SKIP_EN, the REQ-028 stimulus -> z=14, done at edge 65, DIV_CD never entered.
REQ-031 SHALL cover: b=0, a=9, zero=9 -> e=all ones, g=9, gEQz=1, z=64'hFFFF_FFFF_FFFF_FFFF.
REQ-032 SHALL cover: a second start during DIV_AB -> ignored, single done, result from the first operands; then start on the edge after done -> accepted.
REQ-033 SHALL cover: Rst low at edge 40 of a job -> busy=0, z=0 immediately; after release, a new job completes with correct z.
